// File: rtl/round_key_fetch.sv
// round_key_fetch: loads a 128-bit cipher key into an AES-128 key expander and
// fetches assembled 128-bit round keys for the cipher. Option: ROUND_KEY_CACHE_EN.
`default_nettype none

module round_key_fetch #(
  parameter int NR          = 10,
  parameter int EXP_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [127:0] key_in,
  input  logic         key_in_valid,
  output logic         key_in_ready,
  output logic         ke_start,
  output logic [31:0]  ke_cipher_key,
  output logic [3:0]   ke_round_key_num,
  output logic [1:0]   ke_r_index,
  input  logic [31:0]  ke_round_key,
  input  logic         ke_done,
  input  logic         rk_req,
  input  logic [3:0]   rk_num,
  output logic         rk_valid,
  output logic [127:0] rk_data,
  input  logic         rk_ready,
  output logic         key_ready,
  output logic         rk_err,
  output logic         exp_timeout
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_LOAD     = 3'd2;
  localparam logic [2:0] S_WAIT_EXP = 3'd3;
  localparam logic [2:0] S_READY    = 3'd4;
  localparam logic [2:0] S_FETCH    = 3'd5;
  localparam logic [2:0] S_PRESENT  = 3'd6;

  localparam logic [3:0] NR_MAX   = 4'(NR);
  localparam logic [7:0] TO_LAST  = 8'(EXP_TIMEOUT - 1);

  logic [2:0]   state;
  logic [127:0] key_q;
  logic [1:0]   word_cnt;
  logic [7:0]   to_cnt;
  logic [3:0]   num_q;
  logic         cache_hit;

`ifdef ROUND_KEY_CACHE_EN
  logic         tag_valid;
  logic [3:0]   tag_num;
  assign cache_hit = tag_valid && (tag_num == rk_num);
`else
  assign cache_hit = 1'b0;
`endif

  assign key_in_ready     = (state == S_IDLE) || (state == S_READY);
  assign ke_start         = (state == S_START);
  assign ke_round_key_num = (state == S_FETCH) ? num_q : 4'd0;
  assign ke_r_index       = (state == S_FETCH) ? word_cnt : 2'd0;
  assign rk_valid         = (state == S_PRESENT);

  always_comb begin
    ke_cipher_key = 32'd0;
    if (state == S_LOAD) begin
      case (word_cnt)
        2'd0:    ke_cipher_key = key_q[127:96];
        2'd1:    ke_cipher_key = key_q[95:64];
        2'd2:    ke_cipher_key = key_q[63:32];
        default: ke_cipher_key = key_q[31:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      key_q       <= 128'd0;
      word_cnt    <= 2'd0;
      to_cnt      <= 8'd0;
      num_q       <= 4'd0;
      rk_data     <= 128'd0;
      key_ready   <= 1'b0;
      rk_err      <= 1'b0;
      exp_timeout <= 1'b0;
`ifdef ROUND_KEY_CACHE_EN
      tag_valid   <= 1'b0;
      tag_num     <= 4'd0;
`endif
    end else begin
      rk_err <= 1'b0;
      case (state)
        S_IDLE, S_READY: begin
          // A key load takes priority over a concurrent round-key request
          if (key_in_valid) begin
            key_q       <= key_in;
            key_ready   <= 1'b0;
            exp_timeout <= 1'b0;
            state       <= S_START;
`ifdef ROUND_KEY_CACHE_EN
            tag_valid   <= 1'b0;
`endif
          end else if (state == S_READY && rk_req) begin
            if (rk_num > NR_MAX) begin
              rk_err <= 1'b1;
            end else begin
              num_q    <= rk_num;
              word_cnt <= 2'd0;
              state    <= cache_hit ? S_PRESENT : S_FETCH;
            end
          end
        end
        S_START: begin
          word_cnt <= 2'd0;
          state    <= S_LOAD;
        end
        S_LOAD: begin
          word_cnt <= word_cnt + 2'd1;
          if (word_cnt == 2'd3) begin
            to_cnt <= 8'd0;
            state  <= S_WAIT_EXP;
          end
        end
        S_WAIT_EXP: begin
          if (ke_done) begin
            key_ready <= 1'b1;
            state     <= S_READY;
          end else if (to_cnt == TO_LAST) begin
            exp_timeout <= 1'b1;
            state       <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        S_FETCH: begin
          case (word_cnt)
            2'd0:    rk_data[127:96] <= ke_round_key;
            2'd1:    rk_data[95:64]  <= ke_round_key;
            2'd2:    rk_data[63:32]  <= ke_round_key;
            default: rk_data[31:0]   <= ke_round_key;
          endcase
          word_cnt <= word_cnt + 2'd1;
          if (word_cnt == 2'd3) begin
            state <= S_PRESENT;
`ifdef ROUND_KEY_CACHE_EN
            tag_valid <= 1'b1;
            tag_num   <= num_q;
`endif
          end
        end
        S_PRESENT: begin
          if (rk_ready) state <= S_READY;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_round_key_fetch.sv
// Self-checking bench for round_key_fetch with a behavioural AES-128 key expander.
`default_nettype none

module tb_round_key_fetch;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [127:0] key_in;
  logic         key_in_valid;
  logic         key_in_ready;
  logic         ke_start;
  logic [31:0]  ke_cipher_key;
  logic [3:0]   ke_round_key_num;
  logic [1:0]   ke_r_index;
  logic [31:0]  ke_round_key;
  logic         ke_done;
  logic         rk_req;
  logic [3:0]   rk_num;
  logic         rk_valid;
  logic [127:0] rk_data;
  logic         rk_ready;
  logic         key_ready;
  logic         rk_err;
  logic         exp_timeout;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  round_key_fetch #(.NR(10), .EXP_TIMEOUT(255)) dut (
    .clk(clk), .reset_n(reset_n), .key_in(key_in), .key_in_valid(key_in_valid),
    .key_in_ready(key_in_ready), .ke_start(ke_start), .ke_cipher_key(ke_cipher_key),
    .ke_round_key_num(ke_round_key_num), .ke_r_index(ke_r_index),
    .ke_round_key(ke_round_key), .ke_done(ke_done), .rk_req(rk_req), .rk_num(rk_num),
    .rk_valid(rk_valid), .rk_data(rk_data), .rk_ready(rk_ready), .key_ready(key_ready),
    .rk_err(rk_err), .exp_timeout(exp_timeout)
  );

  // ---------------- AES-128 key schedule reference ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'd0, x = a, y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv = 8'd0, s;
    for (int b = 1; b < 256; b++)
      if (a != 8'd0 && gmul(a, 8'(b)) == 8'd1) inv = 8'(b);
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  // word i of the schedule lives at bits [i*32 +: 32]
  function automatic logic [1407:0] expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    logic [1407:0] v;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]) ^ rc, sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) v[i*32 +: 32] = w[i];
    return v;
  endfunction

  function automatic logic [127:0] round_key(input logic [1407:0] v, input int r);
    return {v[(4*r)*32 +: 32], v[(4*r+1)*32 +: 32], v[(4*r+2)*32 +: 32], v[(4*r+3)*32 +: 32]};
  endfunction

  // ---------------- behavioural expander ----------------
  logic [2:0]    ph = 3'd0;
  logic [31:0]   kb0, kb1, kb2;
  logic [1407:0] exp_vec = '0;
  logic          armed = 1'b0;
  int            done_cnt = 0;
  bit            never_done = 1'b0;

  always @(posedge clk) begin
    if (ke_start) begin
      ph    <= 3'd1;
      armed <= 1'b0;
    end else if (ph != 3'd0) begin
      case (ph)
        3'd1: kb0 <= ke_cipher_key;
        3'd2: kb1 <= ke_cipher_key;
        3'd3: kb2 <= ke_cipher_key;
        default: begin
          exp_vec  <= expand({kb0, kb1, kb2, ke_cipher_key});
          armed    <= 1'b1;
          done_cnt <= 44;
        end
      endcase
      ph <= (ph == 3'd4) ? 3'd0 : ph + 3'd1;
    end else if (armed && done_cnt > 0) begin
      done_cnt <= done_cnt - 1;
    end
  end

  assign ke_done = armed && (done_cnt == 0) && !never_done;

  always_comb begin
    ke_round_key = 32'd0;
    if (ke_round_key_num <= 4'd10)
      ke_round_key = exp_vec[(int'(ke_round_key_num) * 4 + int'(ke_r_index)) * 32 +: 32];
  end

  // ---------------- checking helpers ----------------
  logic [1407:0] ref_vec;
  bit            tag_v = 1'b0;
  logic [3:0]    tag_n = 4'd0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic load_key(input logic [127:0] k, input bit with_req);
    key_in       = k;
    key_in_valid = 1'b1;
    if (with_req) begin
      rk_req = 1'b1;
      rk_num = 4'($urandom_range(0, 10));
    end
    chk("load_key_in_ready", key_in_ready, 1);
    tick();
    key_in_valid = 1'b0;
    rk_req       = 1'b0;
    ref_vec      = expand(k);
    tag_v        = 1'b0;
    chk("start_pulse", ke_start, 1);
    chk("start_key_in_ready", key_in_ready, 0);
    chk("start_key_ready_clr", key_ready, 0);
    chk("start_timeout_clr", exp_timeout, 0);
    chk("start_no_err", rk_err, 0);
    for (int w = 0; w < 4; w++) begin
      tick();
      chk($sformatf("load_word%0d", w), ke_cipher_key, k[127 - 32*w -: 32]);
      chk("load_start_low", ke_start, 0);
    end
  endtask

  task automatic wait_key_ready();
    int n = 0;
    while (!key_ready && n < 200) begin
      tick();
      n++;
    end
    chk("key_ready_set", key_ready, 1);
    chk("key_ready_kir", key_in_ready, 1);
  endtask

  task automatic do_req(input logic [3:0] num, input int hold);
    bit hit;
`ifdef ROUND_KEY_CACHE_EN
    hit = tag_v && (tag_n == num);
`else
    hit = 1'b0;
`endif
    rk_num = num;
    rk_req = 1'b1;
    tick();
    rk_req = 1'b0;
    if (num > 4'd10) begin
      chk("err_pulse", rk_err, 1);
      chk("err_no_valid", rk_valid, 0);
      chk("err_no_index", {ke_round_key_num, ke_r_index}, 0);
      tick();
      chk("err_one_cycle", rk_err, 0);
      chk("err_still_ready", key_in_ready, 1);
      chk("err_valid_low", rk_valid, 0);
      return;
    end
    if (!hit) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("fetch_idx%0d", i), ke_r_index, i);
        chk("fetch_num", ke_round_key_num, num);
        chk("fetch_not_valid", rk_valid, 0);
        tick();
      end
      tag_v = 1'b1;
      tag_n = num;
    end
    chk($sformatf("rk_valid_r%0d", num), rk_valid, 1);
    chk($sformatf("rk_data_r%0d", num), rk_data, round_key(ref_vec, int'(num)));
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", rk_valid, 1);
      chk("hold_data", rk_data, round_key(ref_vec, int'(num)));
    end
    rk_ready = 1'b1;
    tick();
    rk_ready = 1'b0;
    chk("post_hs_valid", rk_valid, 0);
    chk("post_hs_ready_state", key_in_ready, 1);
    chk("post_hs_data_hold", rk_data, round_key(ref_vec, int'(num)));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_key_in_ready", key_in_ready, 1);
    chk("rst_ke_start", ke_start, 0);
    chk("rst_cipher_key", ke_cipher_key, 0);
    chk("rst_rk_num", ke_round_key_num, 0);
    chk("rst_r_index", ke_r_index, 0);
    chk("rst_rk_valid", rk_valid, 0);
    chk("rst_rk_data", rk_data, 0);
    chk("rst_key_ready", key_ready, 0);
    chk("rst_rk_err", rk_err, 0);
    chk("rst_timeout", exp_timeout, 0);
  endtask

  localparam logic [127:0] AES_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;

  initial begin
    reset_n = 1'b0; key_in = '0; key_in_valid = 1'b0;
    rk_req = 1'b0; rk_num = 4'd0; rk_ready = 1'b0;
    tick();
    tick();
    chk_reset_outputs();
    reset_n = 1'b1;

    // directed FIPS-197 key
    load_key(AES_KEY, 1'b0);
    wait_key_ready();
    chk("ready_idx_idle", ke_r_index, 0);
    do_req(4'd10, 0);
    chk("vec_round10", rk_data, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
    do_req(4'd1, 3);
    chk("vec_round1", rk_data, 128'ha0fafe17_88542cb1_23a33939_2a6c7605);
    do_req(4'd11, 0);
    do_req(4'd15, 0);
    do_req(4'd10, 0);
    do_req(4'd0, 1);

    // random key loaded together with a dropped request, then random requests
    load_key({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    wait_key_ready();
    for (int i = 0; i < 12; i++)
      do_req(4'($urandom_range(0, 12)), int'($urandom_range(0, 2)));

    // expansion never completes
    never_done = 1'b1;
    load_key({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    tick();
    repeat (254) tick();
    chk("to_not_yet", exp_timeout, 0);
    chk("to_kir_low", key_in_ready, 0);
    tick();
    chk("to_set", exp_timeout, 1);
    chk("to_kir_high", key_in_ready, 1);
    chk("to_key_ready_low", key_ready, 0);
    never_done = 1'b0;

    // new load clears timeout, then reset lands during word 2
    key_in = AES_KEY;
    key_in_valid = 1'b1;
    tick();
    key_in_valid = 1'b0;
    chk("reload_to_clr", exp_timeout, 0);
    chk("reload_start", ke_start, 1);
    tick();
    tick();
    tick();
    chk("mid_load_word2", ke_cipher_key, 32'habf71588);
    reset_n = 1'b0;
    tick();
    tag_v = 1'b0;
    chk_reset_outputs();
    reset_n = 1'b1;
    tick();
    chk("no_restart", ke_start, 0);
    chk("idle_after_rst", key_in_ready, 1);

    load_key(AES_KEY, 1'b0);
    wait_key_ready();
    do_req(4'd10, 0);
    do_req(4'd10, 1);
    chk("repeat_round10", rk_data, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/round_key_fetch.md
Name: round_key_fetch

Overview:
- Host/cipher-side counterpart of the AES-128 key expander: the initiator that drives the expander's load and read interface.
- Accepts a 128-bit cipher key from the host and serialises it as start pulse plus four 32-bit words.
- Waits for expansion done, then serves round-key requests from the cipher datapath.
- For each request it reads the four words via round_key_num/r_index and returns one assembled 128-bit round key on a valid/ready handshake.

Parameters:
NR, 10, number of AES rounds; legal rk_num is 0..NR
EXP_TIMEOUT, 255, max cycles to wait for ke_done before flagging timeout (8-bit counter)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  synchronous active-low reset
key_in  in  128  cipher key; bits 127:96 = word 0
key_in_valid  in  1  host key valid
key_in_ready  out  1  block accepts key this cycle
ke_start  out  1  one-cycle start pulse to expander
ke_cipher_key  out  32  key word to expander
ke_round_key_num  out  4  round-key select to expander
ke_r_index  out  2  word select to expander
ke_round_key  in  32  word returned by expander, combinational on selects
ke_done  in  1  expander done
rk_req  in  1  round-key request pulse, sampled only in READY
rk_num  in  4  requested round number
rk_valid  out  1  rk_data valid
rk_data  out  128  assembled round key; word 0 in 127:96
rk_ready  in  1  consumer accepts rk_data
key_ready  out  1  expansion complete; requests accepted
rk_err  out  1  one-cycle pulse: rk_num > NR
exp_timeout  out  1  sticky: ke_done not seen within EXP_TIMEOUT

Behaviour:
- Reset (reset_n low at clk edge): state IDLE. All outputs 0, except key_in_ready = 1. Key register and timeout counter cleared.
- States: IDLE, START, LOAD, WAIT_EXP, READY, FETCH, PRESENT.
- key_in_ready = 1 in IDLE and READY only.
- IDLE/READY, key_in_valid & key_in_ready:
  - Capture key_in.
  - Clear key_ready and exp_timeout.
  - Go to START.
- START: ke_start = 1 for exactly this cycle (call it T). Go to LOAD.
- LOAD: four cycles, T+1..T+4.
  - Cycle T+1+k drives ke_cipher_key = word k (k = 0..3).
  - ke_cipher_key is 0 outside LOAD.
  - After T+4, go to WAIT_EXP.
- WAIT_EXP:
  - Counter increments each cycle.
  - ke_done high: key_ready = 1, go to READY.
  - Counter reaches EXP_TIMEOUT: set exp_timeout, go to IDLE.
  - ke_done and timeout in the same cycle: done wins.
- READY, rk_req with rk_num <= NR:
  - Latch rk_num, go to FETCH.
  - ke_round_key_num = latched rk_num.
- READY, rk_req with rk_num > NR: rk_err pulses one cycle the next cycle; stay in READY.
- READY, key_in_valid and rk_req in the same cycle: key load wins; request dropped, no rk_err.
- FETCH: four cycles.
  - ke_r_index = 0,1,2,3 in successive cycles.
  - ke_round_key is sampled at the end of each cycle into rk_data slice [127-32*idx -: 32].
  - Go to PRESENT.
- PRESENT:
  - rk_valid = 1; rk_data stable until rk_valid & rk_ready.
  - Then rk_valid drops and state returns to READY.
  - rk_ready ignored when rk_valid = 0.
- Latency: rk_req in cycle R -> rk_valid first high in R+5; back-to-back requests every 6 cycles minimum.
- rk_req outside READY is ignored. rk_data holds its last value after handshake.
- ke_round_key_num and ke_r_index are 0 outside FETCH.
- A reset_n assertion at any time, including mid-LOAD or PRESENT, returns to reset state next edge. ke_start is not re-issued.

Optional Feature:
ROUND_KEY_CACHE_EN
- Defined: a one-entry tag (last fetched rk_num plus valid bit) is kept. In READY, a request whose rk_num matches a valid tag skips FETCH: rk_valid goes high in R+1 with the cached rk_data. The tag is invalidated on key acceptance and reset.
- Undefined: every request performs the full 4-cycle FETCH; no tag logic.

Test Plan:
- Bench uses a golden behavioural expander (ke_done 44 cycles after last word).
- Load key 2b7e1516_28aed2a6_abf71588_09cf4f3c -> ke_start single pulse at T; ke_cipher_key = 2b7e1516, 28aed2a6, abf71588, 09cf4f3c in T+1..T+4; key_ready after ke_done.
- rk_req rk_num=10 -> ke_r_index 0..3 at R+1..R+4; rk_valid at R+5; rk_data = d014f9a8_c9ee2589_e13f0cc8_b6630ca6.
- rk_num=1 with rk_ready held low 3 cycles -> rk_data = a0fafe17_88542cb1_23a33939_2a6c7605, stable and valid until handshake; then state READY.
- rk_num=11 -> rk_err one-cycle pulse; no ke_r_index activity; rk_valid stays 0.
- Expander never asserts ke_done -> exp_timeout set after 255 WAIT_EXP cycles; key_in_ready = 1; new key load clears exp_timeout.
- reset_n low during LOAD word 2 -> next cycle all outputs 0, key_in_ready = 1. With ROUND_KEY_CACHE_EN: repeat rk_num=10 -> rk_valid at R+1 with same data.
